sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single 16-bit external SRAM controller between two requesters: port 0 (CPU memory
//  path, progmem/SRAM regions) and port 1 (DMA/GPU fetch engine).
//  Per-transaction req/ack handshake, round-robin on contention, fixed access window.
//  Sits between the requesters and the SRAM controller: drives write strobe, address, data and mask.
// PARAMETERS
//  ADDR_BITS      16  word address width (16-bit words)
//  DATA_BITS      16  data width; mask width equals DATA_BITS
//  ACCESS_CYCLES  2   cycles the SRAM controller inputs are held per access; legal range 1..15
// PORTS
//  clk_i       in   1          single clock; all state updates on rising edge
//  reset_ni    in   1          reset, synchronous, active-low
//  mN_req_i    in   1          port N (N=0,1) request; held high until mN_ack_o is seen
//  mN_we_i     in   1          port N: 1=write, 0=read; sampled with req
//  mN_addr_i   in   ADDR_BITS  port N word address
//  mN_data_i   in   DATA_BITS  port N write data
//  mN_mask_i   in   DATA_BITS  port N write bit mask (1=write this bit)
//  mN_ack_o    out  1          port N one-cycle completion pulse
//  mN_data_o   out  DATA_BITS  port N read data; valid with ack, held until next read ack on N
//  mem_write_o out  1          write strobe to SRAM controller
//  mem_addr_o  out  ADDR_BITS  address to SRAM controller
//  mem_data_o  out  DATA_BITS  write data to SRAM controller
//  mem_mask_o  out  DATA_BITS  write mask to SRAM controller
//  mem_data_i  in   DATA_BITS  read data from SRAM controller
//  busy_o      out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset (reset_ni=0 at an edge): state=IDLE, cnt=0, last_grant=1 (port 0 wins first tie).
//   All outputs 0, including mN_data_o and mem_*. Reset has priority over everything.
//   Reset mid-access aborts: mem_write_o is 0 the following cycle; no ack is issued.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE:
//   - No req: stay in IDLE.
//   - Exactly one req: grant that port.
//   - Both reqs: grant the port != last_grant; update last_grant to the granted port.
//   - On grant: latch we/addr/data/mask of the granted port into internal regs; cnt=0; go to ACCESS.
//  ACCESS:
//   - mem_addr/data/mask_o are driven from the latched regs.
//   - mem_write_o = latched we, held for all ACCESS_CYCLES cycles.
//   - cnt increments each cycle.
//   - On cnt==ACCESS_CYCLES-1:
//     - Read: capture mem_data_i into the granted port's data_o register.
//     - Go to RESP.
//  RESP:
//   - mN_ack_o=1 for the granted port only; mem_write_o=0; next state IDLE.
//  Outside ACCESS: mem_write_o=0 and mem_mask_o=0; mem_addr_o/mem_data_o hold the last latched value.
//  Latency, uncontended, ACCESS_CYCLES=A:
//   - Request sampled in IDLE at edge k; ACCESS occupies cycles k+1..k+A.
//   - Ack is high in cycle k+A+1.
//   - Throughput: one access per A+2 cycles.
//  Handshake:
//   - The requester drops req in the cycle after it sees ack.
//   - If req is still high when the FSM returns to IDLE, it is a new request.
//   - Req dropped before ack: the latched access still completes and ack still pulses. No cancel.
//   - Inputs changing during ACCESS have no effect; only the latched copy is used.
//  Writes: no data returned; mN_data_o is unchanged by a write ack.
//  Both acks are never high in the same cycle. Starvation bound: a waiting port is granted next IDLE.
// TESTING
//  1. Reset: hold reset_ni=0 2 cycles, all reqs high -> all outputs 0; first grant after release is port 0.
//  2. m0 write addr 0x0123, data 0xBEEF, mask 0xFFFF, A=2 ->
//     mem_write_o high 2 cycles with addr 0x0123/0xBEEF; m0_ack_o pulses 3 cycles after req sample.
//  3. m1 read 0x0123, model returns 0xBEEF ->
//     m1_data_o=0xBEEF with m1_ack_o; mem_write_o stays 0.
//  4. Both reqs held continuously, 4 transactions -> grants alternate 0,1,0,1; each ack 1 cycle, never both.
//  5. m0 req dropped during ACCESS (read 0x0010, mem_data_i=0x5A5A) -> m0_ack_o still pulses;
//     m0_data_o=0x5A5A; FSM returns to IDLE.
//  6. reset_ni=0 in 1st ACCESS cycle of a write -> mem_write_o=0 next cycle; no ack;
//     busy_o=0; next req served normally.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester and SRAM-controller signals of the two-port SRAM arbiter
interface sram_port_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic                 m0_req_i;
    logic                 m0_we_i;
    logic [ADDR_BITS-1:0] m0_addr_i;
    logic [DATA_BITS-1:0] m0_data_i;
    logic [DATA_BITS-1:0] m0_mask_i;
    logic                 m0_ack_o;
    logic [DATA_BITS-1:0] m0_data_o;
    logic                 m1_req_i;
    logic                 m1_we_i;
    logic [ADDR_BITS-1:0] m1_addr_i;
    logic [DATA_BITS-1:0] m1_data_i;
    logic [DATA_BITS-1:0] m1_mask_i;
    logic                 m1_ack_o;
    logic [DATA_BITS-1:0] m1_data_o;
    logic                 mem_write_o;
    logic [ADDR_BITS-1:0] mem_addr_o;
    logic [DATA_BITS-1:0] mem_data_o;
    logic [DATA_BITS-1:0] mem_mask_o;
    logic [DATA_BITS-1:0] mem_data_i;
    logic                 busy_o;
    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_data_i, m0_mask_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_data_i, m1_mask_i,
        input  mem_data_i,
        output m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
        output mem_write_o, mem_addr_o, mem_data_o, mem_mask_o, busy_o
    );
    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_data_i, m0_mask_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_data_i, m1_mask_i,
        output mem_data_i,
        input  m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
        input  mem_write_o, mem_addr_o, mem_data_o, mem_mask_o, busy_o
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one SRAM controller between two req/ack ports
module sram_port_arbiter #(
    parameter int ADDR_BITS     = 16,
    parameter int DATA_BITS     = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input logic                clk_i,
    input logic                reset_ni,
    sram_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [3:0] LAST   = 4'(ACCESS_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 gnt_q, gnt_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [DATA_BITS-1:0] mask_q, mask_d;
    logic [DATA_BITS-1:0] rd0_q, rd0_d;
    logic [DATA_BITS-1:0] rd1_q, rd1_d;
    logic                 pick;

    // on contention the port that did not win last time goes first
    assign pick = (bus.m0_req_i && bus.m1_req_i) ? ~last_q : bus.m1_req_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        if (state_q == IDLE && (bus.m0_req_i || bus.m1_req_i)) begin
            state_d = ACCESS;
            cnt_d   = '0;
            gnt_d   = pick;
            last_d  = pick;
            we_d    = pick ? bus.m1_we_i   : bus.m0_we_i;
            addr_d  = pick ? bus.m1_addr_i : bus.m0_addr_i;
            data_d  = pick ? bus.m1_data_i : bus.m0_data_i;
            mask_d  = pick ? bus.m1_mask_i : bus.m0_mask_i;
        end
        if (state_q == ACCESS) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST) begin
                state_d = RESP;
                rd0_d   = (!we_q && !gnt_q) ? bus.mem_data_i : rd0_q;
                rd1_d   = (!we_q &&  gnt_q) ? bus.mem_data_i : rd1_q;
            end
        end
        if (state_q[1])
            state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign bus.mem_write_o = (state_q == ACCESS) && we_q;
    assign bus.mem_mask_o  = (state_q == ACCESS) ? mask_q : '0;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_data_o  = data_q;
    assign bus.m0_ack_o    = (state_q == RESP) && !gnt_q;
    assign bus.m1_ack_o    = (state_q == RESP) && gnt_q;
    assign bus.m0_data_o   = rd0_q;
    assign bus.m1_data_o   = rd1_q;
    assign bus.busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed stimulus with an ack-driven scoreboard for sram_port_arbiter
module tb_sram_port_arbiter;
    localparam int A = 2;

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] rdata;
    } exp_t;

    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   wcnt = 0;
    int   n;
    exp_t sb[$];
    exp_t e;
    logic [15:0] mem [256] = '{default: 16'h0000};

    always #5 clk_i = ~clk_i;

    sram_port_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16)) bus ();

    sram_port_arbiter #(.ADDR_BITS(16), .DATA_BITS(16), .ACCESS_CYCLES(A)) dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .bus     (bus)
    );

    // SRAM stand-in: masked writes into a small array, two fixed preloaded words
    assign bus.mem_data_i = (bus.mem_addr_o == 16'h0010) ? 16'h5A5A :
                            (bus.mem_addr_o == 16'h0040) ? 16'h1234 : mem[bus.mem_addr_o[7:0]];
    always @(posedge clk_i)
        if (bus.mem_write_o)
            mem[bus.mem_addr_o[7:0]] <= (mem[bus.mem_addr_o[7:0]] & ~bus.mem_mask_o) | (bus.mem_data_o & bus.mem_mask_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input logic p, input logic we, input logic [15:0] a, input logic [15:0] d, input logic [15:0] m);
        if (p) begin
            bus.m1_we_i = we; bus.m1_addr_i = a; bus.m1_data_i = d; bus.m1_mask_i = m; bus.m1_req_i = 1'b1;
        end else begin
            bus.m0_we_i = we; bus.m0_addr_i = a; bus.m0_data_i = d; bus.m0_mask_i = m; bus.m0_req_i = 1'b1;
        end
    endtask

    task automatic issue(input logic p, input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] m, input logic [15:0] rd);
        set_port(p, we, a, d, m);
        sb.push_back('{port: p, we: we, addr: a, rdata: rd});
    endtask

    task automatic wait_ack(input logic p, input logic drop, output int cyc);
        logic ok;
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            ok = p ? bus.m1_ack_o : bus.m0_ack_o;
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL ack_timeout: port %0d got no ack within %0d cycles", p, cyc);
        end
        if (drop) begin
            if (p) bus.m1_req_i = 1'b0;
            else   bus.m0_req_i = 1'b0;
        end
    endtask

    always @(negedge clk_i) begin
        if (!reset_ni) begin
            wcnt = 0;
        end else begin
            if (bus.mem_write_o) wcnt++;
            if (bus.m0_ack_o || bus.m1_ack_o) begin
                chk("ack_exclusive", 32'(bus.m0_ack_o && bus.m1_ack_o), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_ack: got m0=%b m1=%b required none", bus.m0_ack_o, bus.m1_ack_o);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 32'(bus.m1_ack_o), 32'(e.port));
                    chk("mem_addr", 32'(bus.mem_addr_o), 32'(e.addr));
                    chk("write_cycles", 32'(wcnt), e.we ? 32'(A) : 32'd0);
                    if (!e.we)
                        chk("read_data", 32'(e.port ? bus.m1_data_o : bus.m0_data_o), 32'(e.rdata));
                end
                wcnt = 0;
            end
        end
    end

    initial begin
        bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_addr_i = 0; bus.m0_data_i = 0; bus.m0_mask_i = 0;
        bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = 0; bus.m1_data_i = 0; bus.m1_mask_i = 0;
        // 1: reset with both requests pending, then port 0 wins the first tie
        issue(1'b0, 1'b1, 16'h0050, 16'hAAAA, 16'hFFFF, 16'h0000);
        issue(1'b1, 1'b1, 16'h0051, 16'h5555, 16'h00FF, 16'h0000);
        repeat (2) @(negedge clk_i);
        chk("reset_acks", {30'd0, bus.m0_ack_o, bus.m1_ack_o}, 32'd0);
        chk("reset_rdata", {bus.m0_data_o, bus.m1_data_o}, 32'd0);
        chk("reset_mem", {bus.mem_write_o, bus.busy_o, bus.mem_mask_o}, 32'd0);
        chk("reset_mem_ad", {bus.mem_addr_o, bus.mem_data_o}, 32'd0);
        reset_ni = 1'b1;
        wait_ack(1'b0, 1'b1, n);
        wait_ack(1'b1, 1'b1, n);
        // 2: uncontended write and its latency
        @(negedge clk_i);
        issue(1'b0, 1'b1, 16'h0123, 16'hBEEF, 16'hFFFF, 16'h0000);
        wait_ack(1'b0, 1'b1, n);
        chk("write_latency", 32'(n), 32'(A + 1));
        chk("write_keeps_rdata", 32'(bus.m0_data_o), 32'd0);
        // 3: read back through port 1
        @(negedge clk_i);
        issue(1'b1, 1'b0, 16'h0123, 16'h0000, 16'h0000, 16'hBEEF);
        wait_ack(1'b1, 1'b1, n);
        // 4: both requests held, grants alternate 0,1,0,1
        @(negedge clk_i);
        issue(1'b0, 1'b0, 16'h0123, 16'h0000, 16'h0000, 16'hBEEF);
        issue(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h1234);
        sb.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0123, rdata: 16'hBEEF});
        sb.push_back('{port: 1'b1, we: 1'b0, addr: 16'h0040, rdata: 16'h1234});
        wait_ack(1'b0, 1'b0, n);
        wait_ack(1'b1, 1'b0, n);
        wait_ack(1'b0, 1'b1, n);
        wait_ack(1'b1, 1'b1, n);
        // 5: request withdrawn mid-access still completes
        @(negedge clk_i);
        issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h5A5A);
        @(negedge clk_i);
        chk("busy_in_access", 32'(bus.busy_o), 32'd1);
        bus.m0_req_i = 1'b0;
        wait_ack(1'b0, 1'b0, n);
        @(negedge clk_i);
        chk("idle_after_ack", 32'(bus.busy_o), 32'd0);
        // 6: reset during the first access cycle of a write aborts it
        set_port(1'b0, 1'b1, 16'h0060, 16'h1111, 16'hFFFF);
        @(negedge clk_i);
        chk("abort_write_on", 32'(bus.mem_write_o), 32'd1);
        reset_ni = 1'b0;
        bus.m0_req_i = 1'b0;
        @(negedge clk_i);
        chk("abort_write_off", 32'(bus.mem_write_o), 32'd0);
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_rdata", {bus.m0_data_o, bus.m1_data_o}, 32'd0);
        reset_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        issue(1'b1, 1'b0, 16'h0051, 16'h0000, 16'h0000, 16'h0055);
        wait_ack(1'b1, 1'b1, n);
        @(negedge clk_i);
        issue(1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0000, 16'hAAAA);
        wait_ack(1'b0, 1'b1, n);
        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
